// File: rtl/spi_frame_slave_rpi.sv
// SPI mode-0 slave exchanging one FRAME_BITS frame (MSB first) per chip-select, all pins oversampled by CLK.
// Define SPI_FRAME_SEQ_EN to carry a 4-bit sequence number in bits [3:0] and add the SEQ_ERR pulse output.
module spi_frame_slave_rpi #(
    parameter int unsigned FRAME_BITS  = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_CS_N,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    input  logic [FRAME_BITS-1:0] DATA_TX,
    output logic [FRAME_BITS-1:0] DATA_RX,
    output logic                  FRAME_VALID,
    output logic                  FRAME_ERR,
`ifdef SPI_FRAME_SEQ_EN
    output logic                  SEQ_ERR,
`endif
    output logic                  BUSY
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

    // CS_N synchroniser resets asserted so a frame in flight at reset release is ignored
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-2:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] data_rx_q, data_rx_d;
    logic                  miso_q, miso_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [FRAME_BITS-1:0] tx_load;

`ifdef SPI_FRAME_SEQ_EN
    logic [3:0] tx_seq_q, tx_seq_d;
    logic [3:0] last_rx_seq_q, last_rx_seq_d;
    logic       seq_seen_q, seq_seen_d;
    logic       seq_err_q, seq_err_d;

    assign tx_load = {DATA_TX[FRAME_BITS-1:4], tx_seq_q};
`else
    assign tx_load = DATA_TX;
`endif

    // miso_q acts as the MSB of the TX shift register; tx_q holds the bits below it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        miso_d    = miso_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
`ifdef SPI_FRAME_SEQ_EN
        tx_seq_d      = tx_seq_q;
        last_rx_seq_d = last_rx_seq_q;
        seq_seen_d    = seq_seen_q;
        seq_err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    miso_d  = tx_load[FRAME_BITS-1];
                    tx_d    = tx_load[FRAME_BITS-2:0];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                // CS_N rise takes priority over any SCLK edge in the same cycle
                if (cs_rise) begin
                    state_d = ST_DONE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    miso_d = tx_q[FRAME_BITS-2];
                    tx_d   = {tx_q[FRAME_BITS-3:0], 1'b0};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                miso_d  = 1'b0;
                if (cnt_q == CNT_FULL) begin
                    data_rx_d = rx_q;
                    valid_d   = 1'b1;
`ifdef SPI_FRAME_SEQ_EN
                    seq_err_d     = seq_seen_q && (rx_q[3:0] != (last_rx_seq_q + 4'd1));
                    last_rx_seq_d = rx_q[3:0];
                    seq_seen_d    = 1'b1;
                    tx_seq_d      = tx_seq_q + 4'd1;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            miso_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            miso_q    <= miso_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SPI_FRAME_SEQ_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_seq_q      <= '0;
            last_rx_seq_q <= '0;
            seq_seen_q    <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            tx_seq_q      <= tx_seq_d;
            last_rx_seq_q <= last_rx_seq_d;
            seq_seen_q    <= seq_seen_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign SEQ_ERR = seq_err_q;
`endif

    assign SPI_MISO    = miso_q;
    assign DATA_RX     = data_rx_q;
    assign FRAME_VALID = valid_q;
    assign FRAME_ERR   = err_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_spi_frame_slave_rpi.sv
// Scoreboard bench for spi_frame_slave_rpi: a driver pushes expected pulses/MISO words, monitors pop and compare.
module tb_spi_frame_slave_rpi;

    localparam int unsigned FB = 256;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          sclk    = 1'b0;
    logic          cs_n    = 1'b1;
    logic          mosi    = 1'b0;
    logic          miso;
    logic [FB-1:0] data_tx = '0;
    logic [FB-1:0] data_rx;
    logic          frame_valid, frame_err, busy;
`ifdef SPI_FRAME_SEQ_EN
    logic          seq_err;
`endif

    always #5 clk = ~clk;

    spi_frame_slave_rpi #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .SPI_SCLK   (sclk),
        .SPI_CS_N   (cs_n),
        .SPI_MOSI   (mosi),
        .SPI_MISO   (miso),
        .DATA_TX    (data_tx),
        .DATA_RX    (data_rx),
        .FRAME_VALID(frame_valid),
        .FRAME_ERR  (frame_err),
`ifdef SPI_FRAME_SEQ_EN
        .SEQ_ERR    (seq_err),
`endif
        .BUSY       (busy)
    );

    typedef struct {
        bit            is_valid;
        logic [FB-1:0] data;
        bit            exp_seq;
    } pulse_t;

    typedef struct {
        bit            chk;
        logic [FB-1:0] word;
    } miso_t;

    pulse_t pulse_q[$];
    miso_t  miso_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [FB-1:0] rx_hold = '0;
`ifdef SPI_FRAME_SEQ_EN
    logic [3:0] m_tx_seq  = '0;
    logic [3:0] m_last_rx = '0;
    bit         m_seen    = 1'b0;
`endif

    task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        rx_hold = '0;
`ifdef SPI_FRAME_SEQ_EN
        m_tx_seq  = '0;
        m_last_rx = '0;
        m_seen    = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_reset();
        wait_clk(3);
    endtask

    // Push the expected response of one frame, then drive it on the pins
    task automatic send_frame(input logic [FB-1:0] tx, input logic [FB-1:0] rx, input int nbits,
                              input int chg_at, input logic [FB-1:0] tx_chg, input int rst_at,
                              input logic [FB-1:0] miso_exp, input bit miso_chk, input int hold);
        pulse_t p;
        miso_t  m;
        m.chk  = miso_chk;
        m.word = miso_exp;
`ifdef SPI_FRAME_SEQ_EN
        m.word[3:0] = m_tx_seq;
`endif
        miso_q.push_back(m);
        if (rst_at < 0) begin
            p.exp_seq = 1'b0;
            if (nbits == FB) begin
                p.is_valid = 1'b1;
                p.data     = rx;
                rx_hold    = rx;
`ifdef SPI_FRAME_SEQ_EN
                p.exp_seq = m_seen && (rx[3:0] != (m_last_rx + 4'd1));
                m_last_rx = rx[3:0];
                m_seen    = 1'b1;
                m_tx_seq  = m_tx_seq + 4'd1;
`endif
            end else begin
                p.is_valid = 1'b0;
                p.data     = rx_hold;
            end
            pulse_q.push_back(p);
        end

        data_tx = tx;
        cs_n    = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && rst_at != 0) check("busy_in_frame", FB'(busy), FB'(1));
            if (i == chg_at) data_tx = tx_chg;
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_clk(2);
                rst_n = 1'b1;
                model_reset();
                wait_clk(2);
                check("data_rx_after_reset", data_rx, '0);
            end
            mosi = (i < int'(FB)) ? rx[FB-1-i] : 1'b0;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(hold);
        check("busy_idle", FB'(busy), '0);
        check("miso_idle", FB'(miso), '0);
    endtask

    // Pulse monitor: every FRAME_VALID/FRAME_ERR must match the head of the scoreboard
    always @(negedge clk) begin
        pulse_t e;
        if (frame_valid || frame_err) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse", FB'({frame_valid, frame_err}), '0);
            end else begin
                e = pulse_q.pop_front();
                check("pulse_kind", FB'({frame_valid, frame_err}), e.is_valid ? FB'(2'b10) : FB'(2'b01));
                check(e.is_valid ? "data_rx_new" : "data_rx_held", data_rx, e.data);
`ifdef SPI_FRAME_SEQ_EN
                check("seq_err", FB'(seq_err), FB'(e.exp_seq));
`endif
            end
        end
    end

    // MISO monitor: the Pi samples MISO on each SCLK rise; compared as a word at CS_N rise
    logic [FB-1:0] miso_cap = '0;
    int            miso_n   = 0;
    always @(posedge sclk or posedge cs_n) begin
        miso_t m;
        if (cs_n) begin
            if (miso_q.size() > 0) begin
                m = miso_q.pop_front();
                if (m.chk) check("miso_stream", miso_cap, m.word);
            end
            miso_cap = '0;
            miso_n   = 0;
        end else begin
            if (miso_n < int'(FB)) miso_cap = {miso_cap[FB-2:0], miso};
            miso_n++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FB-1:0] tx_pat, rx_a5, rx_5a, rx_b, rx_c, rx_d, rx_e, rx_f, ones, zeros;
        tx_pat = {4{64'h0123_4567_89AB_CDEF}};
        rx_a5  = {32{8'hA5}};
        rx_5a  = {32{8'h5A}};
        rx_b   = {16{16'h3C96}};
        rx_c   = {8{32'hDEAD_BEEF}};
        rx_d   = {8{32'h1357_9BDF}};
        rx_e   = {4{64'hFEDC_BA98_7654_3210}};
        rx_f   = {16{16'h0F1E}};
        ones   = '1;
        zeros  = '0;

        do_reset();
        check("reset_miso", FB'(miso), '0);
        check("reset_data_rx", data_rx, '0);
        check("reset_frame_valid", FB'(frame_valid), '0);
        check("reset_frame_err", FB'(frame_err), '0);
        check("reset_busy", FB'(busy), '0);

        // good frame: MISO = DATA_TX MSB first, DATA_RX = A5...A5
        send_frame(tx_pat, rx_a5, 256, -1, zeros, -1, tx_pat, 1'b1, 10);
        // short and long frames: FRAME_ERR, DATA_RX holds A5...A5
        send_frame(tx_pat, rx_5a, 255, -1, zeros, -1, zeros, 1'b0, 10);
        send_frame(tx_pat, rx_5a, 257, -1, zeros, -1, zeros, 1'b0, 10);
        // DATA_TX change mid-frame has no effect on MISO
        send_frame(zeros, rx_b, 256, 100, ones, -1, zeros, 1'b1, 10);
        // reset at bit 128 with CS_N held low: no pulse, then a clean frame
        send_frame(tx_pat, rx_c, 256, -1, zeros, 128, zeros, 1'b0, 10);
        send_frame(~tx_pat, rx_d, 256, -1, zeros, -1, ~tx_pat, 1'b1, 10);
        // back-to-back frames with minimum CS_N high time
        send_frame(rx_e, rx_e, 256, -1, zeros, -1, rx_e, 1'b1, 5);
        send_frame(rx_f, rx_f, 256, -1, zeros, -1, rx_f, 1'b1, 10);

`ifdef SPI_FRAME_SEQ_EN
        // sequence numbers: RX seq 0,1,3 flags only the third; TX seq reads back 0,1,2
        do_reset();
        send_frame(tx_pat, {rx_a5[FB-1:4], 4'd0}, 256, -1, zeros, -1, {tx_pat[FB-1:4], 4'd0}, 1'b1, 10);
        send_frame(tx_pat, {rx_a5[FB-1:4], 4'd1}, 256, -1, zeros, -1, {tx_pat[FB-1:4], 4'd1}, 1'b1, 10);
        send_frame(tx_pat, {rx_a5[FB-1:4], 4'd3}, 256, -1, zeros, -1, {tx_pat[FB-1:4], 4'd2}, 1'b1, 10);
`endif

        wait_clk(20);
        check("pending_pulses", FB'(pulse_q.size()), '0);
        check("pending_miso", FB'(miso_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
